// File: rtl/ser_rx8.sv
// ser_rx8 -- single-line serial byte receiver.
//
// Frame format: a start bit (0), then 8 data bits, then an optional even
// parity bit, then a stop bit (1). A line sample is taken only on clock
// edges where the bit strobe en is high. Between strobes the receiver
// holds all of its state.
//
// Received bytes are delivered on q with a vld/rdy handshake. If a new
// byte arrives while the previous one is still pending and not being
// accepted, the new byte is dropped and the sticky ovr flag is set.
//
// Build option:
//   SER_RX8_PARITY_EN  - when defined, an even parity bit follows the data
//                        bits and perr reports mismatches. When undefined,
//                        there is no parity state and perr is held at 0.
//
// Reset: rst is asynchronous and active-low.

module ser_rx8 #(
    parameter int MSB_FIRST = 1     // 1: first data bit ends in q[7]; 0: in q[0]
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       si,
    input  logic       en,
    input  logic       rdy,
    input  logic       clr,
    output logic [7:0] q,
    output logic       vld,
    output logic       busy,
    output logic       ferr,
    output logic       perr,
    output logic       ovr
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
`ifdef SER_RX8_PARITY_EN
    localparam logic [2:0] ST_PAR   = 3'd2;
`endif
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [2:0] state_reg, state_next;
    logic [2:0] cnt_reg,   cnt_next;
    logic [7:0] sr_reg,    sr_next;
    logic [7:0] q_reg,     q_next;
    logic       vld_reg,   vld_next;
    logic       ferr_reg,  ferr_next;
    logic       ovr_reg,   ovr_next;
`ifdef SER_RX8_PARITY_EN
    logic       pmis_reg,  pmis_next;   // parity mismatch seen in this frame
    logic       perr_reg,  perr_next;
`endif

    // Shift register contents after taking the current si sample.
    logic [7:0] sr_shift;

    // Byte is complete and well framed on this edge.
    logic       deliver;

    // ------------------------------------------------------------------
    // Shift path: the direction depends on MSB_FIRST. With MSB_FIRST=1
    // bits enter at bit 0 and move up, so the first bit ends in bit 7;
    // otherwise bits enter at bit 7 and move down.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_in
                    assign sr_shift[gi] = si;
                end else begin : g_mv
                    assign sr_shift[gi] = sr_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == 7) begin : g_in
                    assign sr_shift[gi] = si;
                end else begin : g_mv
                    assign sr_shift[gi] = sr_reg[gi+1];
                end
            end
        end
    endgenerate

    // Next-state logic: frame FSM (strobed by en), handshake and ovr clear.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sr_next    = sr_reg;
        q_next     = q_reg;
        vld_next   = vld_reg;
        ferr_next  = 1'b0;
        ovr_next   = ovr_reg;
        deliver    = 1'b0;
`ifdef SER_RX8_PARITY_EN
        pmis_next  = pmis_reg;
        perr_next  = 1'b0;
`endif

        // Consumer takes the pending byte. A delivery below overrides this.
        if (vld_reg && rdy) begin
            vld_next = 1'b0;
        end

        // Clear of the sticky flag. An overrun below overrides this.
        if (clr) begin
            ovr_next = 1'b0;
        end

        if (en) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!si) begin
                        state_next = ST_DATA;
                        cnt_next   = 3'd0;
`ifdef SER_RX8_PARITY_EN
                        pmis_next  = 1'b0;
`endif
                    end
                end

                ST_DATA: begin
                    sr_next  = sr_shift;
                    cnt_next = cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
`ifdef SER_RX8_PARITY_EN
                        state_next = ST_PAR;
`else
                        state_next = ST_STOP;
`endif
                    end
                end

`ifdef SER_RX8_PARITY_EN
                ST_PAR: begin
                    // Even parity: the parity bit equals the XOR of the data.
                    pmis_next  = (si != (^sr_reg));
                    state_next = ST_STOP;
                end
`endif

                ST_STOP: begin
                    if (si) begin
`ifdef SER_RX8_PARITY_EN
                        if (pmis_reg) begin
                            perr_next = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
`else
                        deliver = 1'b1;
`endif
                        state_next = ST_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
`ifdef SER_RX8_PARITY_EN
                        perr_next  = pmis_reg;
`endif
                        state_next = ST_BREAK;
                    end
                end

                ST_BREAK: begin
                    // Wait for the line to return high before hunting for
                    // a new start bit.
                    if (si) begin
                        state_next = ST_IDLE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        // Hand the byte over, or drop it if the previous one is still
        // pending and not being accepted on this edge.
        if (deliver) begin
            if (vld_reg && !rdy) begin
                ovr_next = 1'b1;
            end else begin
                q_next   = sr_reg;
                vld_next = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
            sr_reg    <= 8'h00;
            q_reg     <= 8'h00;
            vld_reg   <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sr_reg    <= sr_next;
            q_reg     <= q_next;
            vld_reg   <= vld_next;
            ferr_reg  <= ferr_next;
            ovr_reg   <= ovr_next;
        end
    end

`ifdef SER_RX8_PARITY_EN
    // Parity tracking registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pmis_reg <= 1'b0;
            perr_reg <= 1'b0;
        end else begin
            pmis_reg <= pmis_next;
            perr_reg <= perr_next;
        end
    end

    assign perr = perr_reg;
`else
    assign perr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign q    = q_reg;
    assign vld  = vld_reg;
    assign busy = (state_reg != ST_IDLE);
    assign ferr = ferr_reg;
    assign ovr  = ovr_reg;

endmodule

// File: tb/tb_ser_rx8.sv
// tb_ser_rx8 -- directed self-checking bench for ser_rx8 (MSB_FIRST=1).
// Works with SER_RX8_PARITY_EN defined or undefined.

`timescale 1ns/1ps

module tb_ser_rx8;

    logic       clk;
    logic       rst;
    logic       si;
    logic       en;
    logic       rdy;
    logic       clr;
    logic [7:0] q;
    logic       vld;
    logic       busy;
    logic       ferr;
    logic       perr;
    logic       ovr;

    int n_vec = 0;
    int n_err = 0;

    ser_rx8 #(.MSB_FIRST(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .si   (si),
        .en   (en),
        .rdy  (rdy),
        .clr  (clr),
        .q    (q),
        .vld  (vld),
        .busy (busy),
        .ferr (ferr),
        .perr (perr),
        .ovr  (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts, and prints one line per check.
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Status flags packed as {vld,busy,ferr,perr,ovr}.
    task automatic chk_out(input string tag, input logic [7:0] exp_q, input logic [4:0] exp_f);
        chk({tag, " q"}, q, exp_q);
        chk({tag, " flags"}, {3'b000, vld, busy, ferr, perr, ovr}, {3'b000, exp_f});
    endtask

    // Apply inputs on the falling edge, return 1ns after the rising edge.
    task automatic drive(input logic s, input logic e, input logic r, input logic c);
        @(negedge clk);
        si  = s;
        en  = e;
        rdy = r;
        clr = c;
        @(posedge clk);
        #1;
    endtask

`ifdef SER_RX8_PARITY_EN
    logic par_flip = 1'b0;
`endif

    // Full frame; rdy/clr values are applied only on the stop-bit edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic rdy_s, input logic clr_s);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            drive(d[i], 1'b1, 1'b0, 1'b0);
        end
`ifdef SER_RX8_PARITY_EN
        drive((^d) ^ par_flip, 1'b1, 1'b0, 1'b0);
`endif
        drive(stop_b, 1'b1, rdy_s, clr_s);
    endtask

    // Frame with two en=0 cycles after every sampled bit; during the gaps
    // the line carries the inverted bit so a stray sample would corrupt it.
    task automatic send_gapped(input logic [7:0] d);
        logic bits [0:10];
        int   nb;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 7; i >= 0; i--) begin
            bits[nb] = d[i]; nb++;
        end
`ifdef SER_RX8_PARITY_EN
        bits[nb] = ^d; nb++;
`endif
        bits[nb] = 1'b1; nb++;
        for (int k = 0; k < nb; k++) begin
            drive(bits[k], 1'b1, 1'b0, 1'b0);
            if (k < nb - 1) begin
                drive(~bits[k], 1'b0, 1'b0, 1'b0);
                drive(~bits[k], 1'b0, 1'b0, 1'b0);
                if (k == 4) chk_out("gap mid-frame", 8'hC3, 5'b01000);
            end
        end
    endtask

    // Hard bound on simulated time.
    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        si  = 1'b1;
        en  = 1'b0;
        rdy = 1'b0;
        clr = 1'b0;
        #1;
        chk_out("reset", 8'h00, 5'b00000);

        // Release reset and idle with the line high.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("idle", 8'h00, 5'b00000);

        // Basic frame, consumer not ready: byte appears on the stop edge.
        send_frame(8'hB5, 1'b1, 1'b0, 1'b0);
        chk_out("basic stop", 8'hB5, 5'b10000);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk_out("basic accept", 8'hB5, 5'b00000);

        // Framing error, then a line held low stays in BREAK.
        send_frame(8'hB5, 1'b0, 1'b0, 1'b0);
        chk_out("ferr stop", 8'hB5, 5'b01100);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("break low 1", 8'hB5, 5'b01000);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("break low 2", 8'hB5, 5'b01000);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("break exit", 8'hB5, 5'b00000);

        // Overrun: second byte dropped while first is pending.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        chk_out("ovr first", 8'h3C, 5'b10000);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        chk_out("ovr second", 8'h3C, 5'b10001);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk_out("ovr clr", 8'h3C, 5'b10000);
        // Clear and new overrun on the same edge: set wins.
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        chk_out("ovr set wins", 8'h3C, 5'b10001);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk_out("ovr clr 2", 8'h3C, 5'b10000);
        // Delivery on the accepting edge replaces q, vld stays, no overrun.
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
        chk_out("accept+deliver", 8'hC3, 5'b10000);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk_out("ovr accept", 8'hC3, 5'b00000);

`ifdef SER_RX8_PARITY_EN
        // Wrong parity bit: perr pulse, byte discarded.
        par_flip = 1'b1;
        send_frame(8'hB5, 1'b1, 1'b0, 1'b0);
        par_flip = 1'b0;
        chk_out("perr stop", 8'hC3, 5'b00010);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("perr after", 8'hC3, 5'b00000);
`endif

        // en gaps mid-frame must not disturb reception.
        send_gapped(8'h5A);
        chk_out("gap stop", 8'h5A, 5'b10000);

        // Mid-frame asynchronous reset after the 4th data bit.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk_out("pre-reset", 8'h5A, 5'b11000);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_out("async reset", 8'h00, 5'b00000);
        @(negedge clk);
        rst = 1'b1;
        si  = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        chk_out("post-reset frame", 8'h5A, 5'b10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ser_rx8.md
SER_RX8 -- requirements
Module: ser_rx8

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning: 1 = first data bit received lands in q[7], 0 = first data bit lands in q[0].
REQ-002 SHALL have port clk  input  1  rising-edge system clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port si  input  1  serial line in, for example shift-register serial out; idle level 1.
REQ-005 SHALL have port en  input  1  bit strobe; si is sampled only on clock edges where en=1.
REQ-006 SHALL have port rdy  input  1  consumer ready; byte is accepted on the edge where vld=1 and rdy=1.
REQ-007 SHALL have port clr  input  1  synchronous clear of the sticky ovr flag.
REQ-008 SHALL have port q  output  8  received byte; held stable while vld=1.
REQ-009 SHALL have port vld  output  1  byte available.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port ferr  output  1  one-cycle pulse on framing error (stop bit = 0).
REQ-012 SHALL have port perr  output  1  one-cycle pulse on parity error.
REQ-013 SHALL have port ovr  output  1  sticky overrun flag.

Function
REQ-014 SHALL implement the FSM states IDLE, DATA, PAR, STOP and BREAK; only edges with en=1 advance the FSM.
REQ-015 IDLE: sampling si=0 SHALL go to DATA and clear the 3-bit bit counter; sampling si=1 SHALL stay in IDLE.
REQ-016 DATA: SHALL shift in 8 samples per MSB_FIRST, then go to PAR (PARITY_EN defined) or STOP (PARITY_EN undefined) after the 8th sample.
REQ-017 PAR: SHALL sample one bit and record a mismatch against even parity over the 8 data bits, then go to STOP.
REQ-018 STOP, si=1 with no parity mismatch: SHALL deliver the byte, so that q and vld update on that same edge, giving 0 cycles of latency after the stop sample, then go to IDLE.
REQ-019 STOP, si=1 with a parity mismatch: SHALL pulse perr on that edge, discard the byte (q and vld unchanged), and go to IDLE.
REQ-020 STOP, si=0: SHALL pulse ferr on that edge, discard the byte, and go to BREAK; a parity mismatch in the same frame SHALL also pulse perr.
REQ-021 BREAK: SHALL stay until si=1 is sampled, then go to IDLE, so that a line held low does not re-trigger a start.
REQ-022 Handshake: the edge with vld=1 and rdy=1 SHALL clear vld, unless a delivery occurs on the same edge.
REQ-023 Delivery while vld=1 and rdy=1 on the same edge: the new byte SHALL replace q, vld SHALL stay 1, and ovr SHALL NOT be set.
REQ-024 Delivery while vld=1 and rdy=0: the new byte SHALL be dropped, q retained, and ovr set to 1.
REQ-025 ovr SHALL stay 1 until an edge with clr=1; if clr=1 and a new overrun occur on the same edge, ovr SHALL remain 1 (set wins).
REQ-026 en=0 for any number of cycles mid-frame SHALL freeze the FSM, the counter and the shift register.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, bit counter 0, shift register 0, q=8'h00, vld=0, busy=0, ferr=0, perr=0 and ovr=0, regardless of clk, including mid-frame.
REQ-028 After rst returns to 1, the first start bit SHALL be detected on the first en=1 edge that samples si=0.

Configuration
REQ-029 SHALL use the macro SER_RX8_PARITY_EN.
REQ-030 With SER_RX8_PARITY_EN defined, each frame SHALL be start, 8 data, even parity, stop (11 en-samples), and perr SHALL be active.
REQ-031 With SER_RX8_PARITY_EN undefined, each frame SHALL be start, 8 data, stop (10 en-samples), the PAR state SHALL be absent, and perr SHALL be tied to 0 with the port retained.

Verification
REQ-032 Reset and idle: rst=0 then rst=1, en=1, si=1 for 20 cycles -> q=8'h00, vld=0, busy=0, all flags 0.
REQ-033 Basic frame: MSB_FIRST=1, rdy=0, frame 0,1,0,1,1,0,1,0,1,[parity 1],1 -> q=8'hB5 and vld=1 on the stop edge; rdy=1 for one edge -> vld=0.
REQ-034 Framing error: 0, 8'hB5 data, stop=0 -> ferr pulses 1 cycle, vld=0, busy=1 (BREAK) until si=1 is sampled.
REQ-035 Overrun: frames 8'h3C then 8'hC3 with rdy=0 -> q=8'h3C, ovr=1; clr=1 -> ovr=0; frame repeated with rdy=1 on the stop edge -> q=8'hC3, ovr=0.
REQ-036 Parity error (macro defined): 8'hB5 with parity bit 0 -> perr pulses 1 cycle, q is unchanged.
REQ-037 Mid-frame reset and en gaps: rst=0 after the 4th data bit -> all outputs 0 at once, and the next full 8'h5A frame is received correctly; en toggling 1/0 mid-frame -> same 8'h5A result.
